// File: rtl/alu_74382_seq.sv
// Bit-slice sequencer: runs one WIDTH-bit operation on a narrow alu_74382 slice.
// Ports: clk/rst_n; req_* (valid/ready request); rsp_* (valid/ready response); busy; alu_* slice drive/return.
package alu_74382_pkg;
    localparam int ORIG_OPERAND_W = 4;
    localparam int SELECT_W       = 3;

    localparam logic [SELECT_W-1:0] OP_CLEAR   = 3'd0;
    localparam logic [SELECT_W-1:0] OP_B_SUB_A = 3'd1;
    localparam logic [SELECT_W-1:0] OP_A_SUB_B = 3'd2;
    localparam logic [SELECT_W-1:0] OP_ADD     = 3'd3;
    localparam logic [SELECT_W-1:0] OP_XOR     = 3'd4;
    localparam logic [SELECT_W-1:0] OP_OR      = 3'd5;
    localparam logic [SELECT_W-1:0] OP_AND     = 3'd6;
    localparam logic [SELECT_W-1:0] OP_PRESET  = 3'd7;
endpackage

module alu_74382_seq
    import alu_74382_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = ORIG_OPERAND_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SELECT_W-1:0] req_op,
    input  logic [WIDTH-1:0]    req_a,
    input  logic [WIDTH-1:0]    req_b,
    input  logic                req_carry_in,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_result,
    output logic                rsp_carry_out,
    output logic                rsp_overflow,
    output logic                busy,
    output logic [SELECT_W-1:0] alu_sel,
    output logic                alu_carry_in,
    output logic [SLICE_W-1:0]  alu_port_a,
    output logic [SLICE_W-1:0]  alu_port_b,
    input  logic [SLICE_W-1:0]  alu_result,
    input  logic                alu_carry_out,
    input  logic                alu_overflow
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [SELECT_W-1:0] op_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                cin_q;
    logic                carry_q;
    logic                last;
    logic                chain;

    assign last  = (idx_q == IDX_W'(N - 1));
    // Only the arithmetic ops ripple carry between slices.
    assign chain = (op_q == OP_ADD) || (op_q == OP_A_SUB_B) || (op_q == OP_B_SUB_A);

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_valid) state_d = RUN;
            RUN:  if (last) state_d = DONE;
            DONE: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_sel      = OP_CLEAR;
        alu_carry_in = 1'b0;
        alu_port_a   = '0;
        alu_port_b   = '0;
        if (state_q == RUN) begin
            alu_sel      = op_q;
            alu_carry_in = (idx_q != '0 && chain) ? carry_q : cin_q;
            for (int i = 0; i < N; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    alu_port_a = a_q[i*SLICE_W +: SLICE_W];
                    alu_port_b = b_q[i*SLICE_W +: SLICE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= '0;
            op_q          <= OP_CLEAR;
            a_q           <= '0;
            b_q           <= '0;
            cin_q         <= 1'b0;
            carry_q       <= 1'b0;
            rsp_result    <= '0;
            rsp_carry_out <= 1'b0;
            rsp_overflow  <= 1'b0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                op_q       <= req_op;
                a_q        <= req_a;
                b_q        <= req_b;
                cin_q      <= req_carry_in;
                carry_q    <= req_carry_in;
                rsp_result <= '0;
                idx_q      <= '0;
            end else if (state_q == RUN) begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        rsp_result[i*SLICE_W +: SLICE_W] <= alu_result;
                    end
                end
                carry_q <= alu_carry_out;
                if (last) begin
                    idx_q         <= '0;
                    rsp_carry_out <= alu_carry_out;
                    rsp_overflow  <= alu_overflow;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_74382_seq.sv
// Directed bench for alu_74382_seq with a behavioural 4-bit alu_74382 slice.
// Ports: none; drives the sequencer and checks against hand-computed vectors.
module tb_alu_74382_seq;
    import alu_74382_pkg::*;

    localparam int WIDTH   = 16;
    localparam int SLICE_W = ORIG_OPERAND_W;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic [SELECT_W-1:0] req_op;
    logic [WIDTH-1:0]    req_a;
    logic [WIDTH-1:0]    req_b;
    logic                req_carry_in;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [WIDTH-1:0]    rsp_result;
    logic                rsp_carry_out;
    logic                rsp_overflow;
    logic                busy;
    logic [SELECT_W-1:0] alu_sel;
    logic                alu_carry_in;
    logic [SLICE_W-1:0]  alu_port_a;
    logic [SLICE_W-1:0]  alu_port_b;
    logic [SLICE_W-1:0]  alu_result;
    logic                alu_carry_out;
    logic                alu_overflow;

    int n_checks = 0;
    int n_fails  = 0;

    alu_74382_seq #(.WIDTH(WIDTH), .SLICE_W(SLICE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_carry_in(req_carry_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry_out(rsp_carry_out),
        .rsp_overflow(rsp_overflow), .busy(busy),
        .alu_sel(alu_sel), .alu_carry_in(alu_carry_in),
        .alu_port_a(alu_port_a), .alu_port_b(alu_port_b),
        .alu_result(alu_result), .alu_carry_out(alu_carry_out),
        .alu_overflow(alu_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 74382 slice.
    logic [SLICE_W-1:0] opx, opy;
    logic [SLICE_W:0]   sum;
    always_comb begin
        opx = alu_port_a;
        opy = alu_port_b;
        if (alu_sel == OP_A_SUB_B) opy = ~alu_port_b;
        if (alu_sel == OP_B_SUB_A) begin
            opx = alu_port_b;
            opy = ~alu_port_a;
        end
        sum = {1'b0, opx} + {1'b0, opy} + {{SLICE_W{1'b0}}, alu_carry_in};
        alu_result    = '0;
        alu_carry_out = 1'b0;
        alu_overflow  = 1'b0;
        case (alu_sel)
            OP_ADD, OP_A_SUB_B, OP_B_SUB_A: begin
                alu_result    = sum[SLICE_W-1:0];
                alu_carry_out = sum[SLICE_W];
                alu_overflow  = (opx[SLICE_W-1] == opy[SLICE_W-1]) &&
                                (sum[SLICE_W-1] != opx[SLICE_W-1]);
            end
            OP_XOR:    alu_result = alu_port_a ^ alu_port_b;
            OP_OR:     alu_result = alu_port_a | alu_port_b;
            OP_AND:    alu_result = alu_port_a & alu_port_b;
            OP_PRESET: alu_result = '1;
            default:   alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, check per-slice carry-in, latency and the response.
    task automatic run_op(input string tag,
                          input logic [SELECT_W-1:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin,
                          input logic [WIDTH-1:0] exp_res,
                          input logic exp_co, input logic exp_ov,
                          input logic [3:0] exp_cins);
        logic [3:0] cins;
        req_op = op;
        req_a = a;
        req_b = b;
        req_carry_in = cin;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk({tag, " sel"}, 32'(alu_sel), 32'(op));
        for (int i = 0; i < 4; i++) begin
            cins[i] = alu_carry_in;
            chk({tag, " busy"}, 32'(rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        chk({tag, " cins"}, 32'(cins), 32'(exp_cins));
        chk({tag, " valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " result"}, 32'(rsp_result), 32'(exp_res));
        chk({tag, " cout"}, 32'(rsp_carry_out), 32'(exp_co));
        chk({tag, " ovf"}, 32'(rsp_overflow), 32'(exp_ov));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, " idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = OP_CLEAR;
        req_a = '0;
        req_b = '0;
        req_carry_in = 1'b0;
        rsp_ready = 1'b0;
        #12;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst result", 32'(rsp_result), 32'd0);
        chk("rst alu_sel", 32'(alu_sel), 32'(OP_CLEAR));
        chk("rst alu_a", 32'(alu_port_a), 32'd0);
        chk("rst alu_cin", 32'(alu_carry_in), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("add1", OP_ADD, 16'h1234, 16'h0FCF, 1'b0, 16'h2203, 1'b0, 1'b0, 4'b1110);
        run_op("add2", OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110);
        run_op("add_ov", OP_ADD, 16'h7000, 16'h1000, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b0000);
        run_op("asubb", OP_A_SUB_B, 16'h5000, 16'h0001, 1'b1, 16'h4FFF, 1'b1, 1'b0, 4'b0001);
        run_op("bsuba", OP_B_SUB_A, 16'h0002, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 4'b0001);
        run_op("xor", OP_XOR, 16'hA5A5, 16'h0FF0, 1'b1, 16'hAA55, 1'b0, 1'b0, 4'b1111);
        run_op("preset", OP_PRESET, 16'h1234, 16'h5678, 1'b0, 16'hFFFF, 1'b0, 1'b0, 4'b0000);
        run_op("clear", OP_CLEAR, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0, 4'b1111);
        run_op("and", OP_AND, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 1'b0, 1'b0, 4'b0000);

        chk("idle alu_sel", 32'(alu_sel), 32'(OP_CLEAR));
        chk("idle alu_b", 32'(alu_port_b), 32'd0);
        chk("idle hold", 32'(rsp_result), 32'h0000F000);

        // Backpressure in DONE.
        req_op = OP_OR;
        req_a = 16'h1200;
        req_b = 16'h0034;
        req_carry_in = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp valid", 32'(rsp_valid), 32'd1);
        chk("bp result", 32'(rsp_result), 32'h00001234);
        req_op = OP_PRESET;
        for (int i = 0; i < 3; i++) begin
            req_valid = (i == 1);
            @(posedge clk);
            #1;
            chk("bp hold valid", 32'(rsp_valid), 32'd1);
            chk("bp hold result", 32'(rsp_result), 32'h00001234);
            chk("bp req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("bp idle", 32'(req_ready), 32'd1);
        chk("bp no rsp", 32'(rsp_valid), 32'd0);
        chk("bp not busy", 32'(busy), 32'd0);
        req_op = OP_XOR;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp accept", 32'(busy), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("bp new result", 32'(rsp_result), 32'h00001234);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Reset in the middle of RUN.
        req_op = OP_ADD;
        req_a = 16'h1111;
        req_b = 16'h2222;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid idx2 a", 32'(alu_port_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst busy", 32'(busy), 32'd0);
        chk("mrst valid", 32'(rsp_valid), 32'd0);
        chk("mrst result", 32'(rsp_result), 32'd0);
        chk("mrst alu_sel", 32'(alu_sel), 32'(OP_CLEAR));
        chk("mrst alu_a", 32'(alu_port_a), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mrst no rsp", 32'(rsp_valid), 32'd0);
        run_op("add_post", OP_ADD, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
